// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud
// constants, used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_DBIT    = 8;    // data bits per frame
    localparam int DEF_SB_TICK = 16;   // stop length in oversample ticks
    localparam int DEF_DVSR    = 163;  // clk cycles per 16x oversample tick

    // Oversample ticks per start/data bit.
    localparam int TICKS_PER_BIT = 16;

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter-side bundle: FIFO read port plus serial line and status.
//
// Handshake: the FIFO offers a word whenever fifo_empty is low (valid =
// !fifo_empty, data = fifo_data). The transmitter accepts it by raising
// fifo_rd for exactly one cycle; the FIFO pops on the rising edge that
// ends that cycle. fifo_rd is never raised while fifo_empty is high and
// never on two consecutive cycles.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DBIT = DEF_DBIT
);
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_data;
    logic            fifo_rd;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;
    uart_state_t     dbg_state;

    // Transmitter side.
    modport master (
        input  fifo_empty, fifo_data,
        output fifo_rd, tx, tx_busy, tx_done_tick, dbg_state
    );

    // FIFO / observer side.
    modport slave (
        output fifo_empty, fifo_data,
        input  fifo_rd, tx, tx_busy, tx_done_tick, dbg_state
    );
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Baud divider: mod-DVSR counter producing one oversample tick every
// DVSR clock cycles, with a synchronous clear to phase-align bit timing.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR = DEF_DVSR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DVSR);

    logic [W-1:0] cnt;

    // Count 0..DVSR-1 and wrap; reset or clear forces phase 0.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (cnt == W'(DVSR - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DVSR - 1));

endmodule

// File: rtl/uart.sv
// UART transmitter: pops words from a FIFO and serialises them as
// start bit, DBIT data bits LSB first, and a SB_TICK-tick stop period.
// Consecutive frames run back to back when the FIFO stays non-empty.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.master bus
);
    localparam int TW = $clog2((SB_TICK > TICKS_PER_BIT) ? SB_TICK : TICKS_PER_BIT);
    localparam int BW = $clog2(DBIT);

    uart_state_t     state;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            tx_r;
    logic            rd_r;
    logic            busy_r;
    logic            done_r;
    logic            tick;
    logic            baud_clr;

    // The divider is held at phase 0 in IDLE, so entry to START from IDLE
    // starts a fresh bit period. Entry to START from STOP happens on the
    // tick where the divider wraps to 0 anyway, giving the same alignment.
    assign baud_clr = (state == IDLE);

    baud_gen #(.DVSR(DVSR)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_r     <= 1'b1;
            rd_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            rd_r   <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (!bus.fifo_empty) begin
                        rd_r     <= 1'b1;
                        shreg    <= bus.fifo_data;
                        tick_cnt <= '0;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= START;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == TW'(TICKS_PER_BIT - 1)) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            tx_r     <= shreg[0];
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == TW'(TICKS_PER_BIT - 1)) begin
                            tick_cnt <= '0;
                            if (bit_cnt == BW'(DBIT - 1)) begin
                                tx_r  <= 1'b1;
                                state <= STOP;
                            end else begin
                                shreg   <= shreg >> 1;
                                tx_r    <= shreg[1];
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == TW'(SB_TICK - 1)) begin
                            tick_cnt <= '0;
                            done_r   <= 1'b1;
                            if (!bus.fifo_empty) begin
                                // Chain straight into the next frame.
                                rd_r  <= 1'b1;
                                shreg <= bus.fifo_data;
                                tx_r  <= 1'b0;
                                state <= START;
                            end else begin
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx           = tx_r;
    assign bus.fifo_rd      = rd_r;
    assign bus.tx_busy      = busy_r;
    assign bus.tx_done_tick = done_r;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: FIFO models feed two instances (1 and 2 stop
// bits), a scoreboard of expected words is checked cycle by cycle on tx.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DBIT    = 8;
    localparam int DVSR    = 2;
    localparam int BIT_CYC = 16 * DVSR;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DBIT-1:0] exp_q[$];
    logic [DBIT-1:0] fifo_a[$];
    logic [DBIT-1:0] fifo_b[$];

    int   pops_a    = 0;
    int   pops_b    = 0;
    int   proto_err = 0;
    int   done_a    = 0;
    logic rd_prev_a = 1'b0;
    logic rd_prev_b = 1'b0;

    uart_tx_if #(.DBIT(DBIT)) bus_a ();
    uart_tx_if #(.DBIT(DBIT)) bus_b ();

    uart_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    uart_tx #(.DBIT(DBIT), .SB_TICK(32), .DVSR(DVSR)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO models: pop on the edge that ends a fifo_rd cycle, then refresh.
    initial begin
        logic [DBIT-1:0] tmp;
        forever begin
            bus_a.fifo_empty = (fifo_a.size() == 0);
            bus_a.fifo_data  = (fifo_a.size() == 0) ? '0 : fifo_a[0];
            bus_b.fifo_empty = (fifo_b.size() == 0);
            bus_b.fifo_data  = (fifo_b.size() == 0) ? '0 : fifo_b[0];
            @(posedge clk);
            if (bus_a.fifo_rd === 1'b1) begin
                if (fifo_a.size() > 0) begin
                    tmp = fifo_a.pop_front();
                    pops_a++;
                end else begin
                    proto_err++;
                end
            end
            if (bus_b.fifo_rd === 1'b1) begin
                if (fifo_b.size() > 0) begin
                    tmp = fifo_b.pop_front();
                    pops_b++;
                end else begin
                    proto_err++;
                end
            end
            #1;
        end
    end

    // Pop-protocol watcher and done-tick counter.
    always @(negedge clk) begin
        if (reset) begin
            if (bus_a.fifo_rd && bus_a.fifo_empty) proto_err++;
            if (bus_a.fifo_rd && rd_prev_a)        proto_err++;
            if (bus_b.fifo_rd && bus_b.fifo_empty) proto_err++;
            if (bus_b.fifo_rd && rd_prev_b)        proto_err++;
        end
        rd_prev_a = bus_a.fifo_rd;
        rd_prev_b = bus_b.fifo_rd;
        if (bus_a.tx_done_tick === 1'b1) done_a++;
    end

    function automatic logic cur_tx(input logic sel);
        return sel ? bus_b.tx : bus_a.tx;
    endfunction
    function automatic logic cur_rd(input logic sel);
        return sel ? bus_b.fifo_rd : bus_a.fifo_rd;
    endfunction
    function automatic logic cur_done(input logic sel);
        return sel ? bus_b.tx_done_tick : bus_a.tx_done_tick;
    endfunction
    function automatic logic cur_busy(input logic sel);
        return sel ? bus_b.tx_busy : bus_a.tx_busy;
    endfunction

    // Waits for a pop, pops the scoreboard and checks every cycle of the frame.
    // Returns at the negedge of the cycle right after the frame.
    task automatic check_frame(input logic sel, input int sb_tick,
                               input bit no_gap, input string name);
        int waited;
        int len;
        int idx;
        int bad_tx;
        int bad_done;
        int bad_rd;
        int bad_busy;
        logic exp_bit;
        logic [DBIT-1:0] word;
        waited = 0;
        while (cur_rd(sel) !== 1'b1 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cur_rd(sel) !== 1'b1) begin
            $display("FAIL %s start: no fifo_rd after %0d cycles, required a pop", name, waited);
            n_fail++;
            return;
        end
        if (no_gap) begin
            n_cmp++;
            if (waited != 0) begin
                $display("FAIL %s gap: idle gap %0d cycles, required 0", name, waited);
                n_fail++;
            end
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            $display("FAIL %s scoreboard: queue empty, required a word", name);
            n_fail++;
            return;
        end
        word = exp_q.pop_front();
        len = (1 + DBIT) * BIT_CYC + sb_tick * DVSR;
        bad_tx = 0; bad_done = 0; bad_rd = 0; bad_busy = 0;
        for (int c = 0; c < len; c++) begin
            if (c < BIT_CYC) begin
                exp_bit = 1'b0;
            end else if (c < (1 + DBIT) * BIT_CYC) begin
                idx = (c - BIT_CYC) / BIT_CYC;
                exp_bit = word[idx];
            end else begin
                exp_bit = 1'b1;
            end
            if (cur_tx(sel) !== exp_bit) bad_tx++;
            if (c > 0 && cur_done(sel) !== 1'b0) bad_done++;
            if (c > 0 && cur_rd(sel) !== 1'b0) bad_rd++;
            if (cur_busy(sel) !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad_tx != 0) begin
            $display("FAIL %s tx: word %h has %0d wrong cycles, required 0", name, word, bad_tx);
            n_fail++;
        end
        n_cmp++;
        if (bad_done != 0 || bad_rd != 0 || bad_busy != 0) begin
            $display("FAIL %s strobes: early done %0d, extra rd %0d, busy low %0d, required 0/0/0",
                     name, bad_done, bad_rd, bad_busy);
            n_fail++;
        end
        n_cmp++;
        if (cur_done(sel) !== 1'b1) begin
            $display("FAIL %s done: tx_done_tick %b at cycle %0d, required 1", name, cur_done(sel), len);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus_a.tx !== 1'b1) begin
            $display("FAIL reset_tx: tx %b, required 1", bus_a.tx); n_fail++;
        end
        n_cmp++;
        if (bus_a.fifo_rd !== 1'b0) begin
            $display("FAIL reset_rd: fifo_rd %b, required 0", bus_a.fifo_rd); n_fail++;
        end
        n_cmp++;
        if (bus_a.tx_busy !== 1'b0 || bus_a.tx_done_tick !== 1'b0) begin
            $display("FAIL reset_busy: busy %b done %b, required 0 0", bus_a.tx_busy, bus_a.tx_done_tick);
            n_fail++;
        end
        n_cmp++;
        if (bus_a.dbg_state !== IDLE || bus_b.tx !== 1'b1 || bus_b.tx_busy !== 1'b0) begin
            $display("FAIL reset_state: state_a %0d tx_b %b busy_b %b, required 0 1 0",
                     bus_a.dbg_state, bus_b.tx, bus_b.tx_busy);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int p0;
        p0 = pops_a;
        fifo_a.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        check_frame(1'b0, 16, 1'b0, "single_a5");
        n_cmp++;
        if (bus_a.tx_busy !== 1'b0 || bus_a.dbg_state !== IDLE) begin
            $display("FAIL single_idle: busy %b state %0d, required 0 0", bus_a.tx_busy, bus_a.dbg_state);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pops_a - p0 != 1) begin
            $display("FAIL single_pops: %0d pops, required 1", pops_a - p0); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [DBIT-1:0] words[3];
        words = '{8'h00, 8'hFF, 8'h55};
        p0 = pops_a;
        foreach (words[i]) begin
            fifo_a.push_back(words[i]);
            exp_q.push_back(words[i]);
        end
        check_frame(1'b0, 16, 1'b0, "b2b_0");
        check_frame(1'b0, 16, 1'b1, "b2b_1");
        check_frame(1'b0, 16, 1'b1, "b2b_2");
        n_cmp++;
        if (bus_a.tx_busy !== 1'b0 || bus_a.dbg_state !== IDLE) begin
            $display("FAIL b2b_idle: busy %b state %0d, required 0 0", bus_a.tx_busy, bus_a.dbg_state);
            n_fail++;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (pops_a - p0 != 3) begin
            $display("FAIL b2b_pops: %0d pops, required 3", pops_a - p0); n_fail++;
        end
    endtask

    task automatic test_two_stop();
        fifo_b.push_back(8'h96);
        exp_q.push_back(8'h96);
        check_frame(1'b1, 32, 1'b0, "two_stop");
        n_cmp++;
        if (bus_b.tx_busy !== 1'b0 || pops_b != 1) begin
            $display("FAIL two_stop_end: busy %b pops %0d, required 0 1", bus_b.tx_busy, pops_b);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int d0;
        int p0;
        int bad_tx;
        waited = 0;
        fifo_a.push_back(8'h3C);
        while (bus_a.fifo_rd !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        // Into data bit 1 of 0x3C, which is 0.
        repeat (2 * BIT_CYC + 10) @(negedge clk);
        n_cmp++;
        if (bus_a.tx !== 1'b0) begin
            $display("FAIL abort_pre: tx %b before reset, required 0", bus_a.tx); n_fail++;
        end
        d0 = done_a;
        p0 = pops_a;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus_a.tx !== 1'b1 || bus_a.tx_busy !== 1'b0 || bus_a.fifo_rd !== 1'b0) begin
            $display("FAIL abort_edge: tx %b busy %b rd %b, required 1 0 0",
                     bus_a.tx, bus_a.tx_busy, bus_a.fifo_rd);
            n_fail++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad_tx = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus_a.tx !== 1'b1) bad_tx++;
        end
        n_cmp++;
        if (done_a != d0 || pops_a != p0 || bad_tx != 0) begin
            $display("FAIL abort_quiet: done %0d pops %0d tx-low %0d, required 0 0 0",
                     done_a - d0, pops_a - p0, bad_tx);
            n_fail++;
        end
        fifo_a.push_back(8'h81);
        exp_q.push_back(8'h81);
        check_frame(1'b0, 16, 1'b0, "after_abort_81");
    endtask

    task automatic test_idle();
        int p0;
        int bad_tx;
        int bad_rd;
        p0 = pops_a;
        bad_tx = 0;
        bad_rd = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus_a.tx !== 1'b1) bad_tx++;
            if (bus_a.fifo_rd !== 1'b0) bad_rd++;
        end
        n_cmp++;
        if (bad_tx != 0 || bad_rd != 0 || pops_a != p0) begin
            $display("FAIL idle_hold: tx-low %0d rd %0d pops %0d, required 0 0 0",
                     bad_tx, bad_rd, pops_a - p0);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop();
        test_reset_mid();
        test_idle();
        n_cmp++;
        if (proto_err != 0) begin
            $display("FAIL pop_protocol: %0d violations, required 0", proto_err); n_fail++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_left: %0d words, required 0", exp_q.size()); n_fail++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, stop-bit length in oversample ticks (16/24/32 = 1/1.5/2 stop bits).
REQ-003 The block SHALL have parameter DVSR, default 163, clk cycles per 16x oversample tick (≥2).
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port fifo_empty, input, 1, transmit FIFO empty flag.
REQ-007 The block SHALL have port fifo_data, input, DBIT, transmit FIFO head word.
REQ-008 The block SHALL have port fifo_rd, output, 1, one-cycle FIFO pop strobe.
REQ-009 The block SHALL have port tx, output, 1, serial line, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port tx_done_tick, output, 1, one-cycle pulse at the end of each stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP; the internal tick counter is 0..SB_TICK-1; the bit counter is 0..DBIT-1.
REQ-013 The baud sub-counter SHALL count 0..DVSR-1, assert tick on DVSR-1, and clear to 0 on every entry to START, so that every data/start bit lasts exactly 16*DVSR cycles.
REQ-014 In IDLE with fifo_empty=0, the block SHALL assert fifo_rd for one cycle, capture fifo_data into the shift register in that same cycle, and move to START.
REQ-015 In IDLE with fifo_empty=1, the block SHALL hold tx=1 and fifo_rd=0.
REQ-016 In START, tx SHALL be 0; after 16 ticks the block SHALL move to DATA with bit counter 0.
REQ-017 In DATA, tx SHALL be the shift-register LSB; every 16 ticks the register shifts right; after bit DBIT-1 the block moves to STOP.
REQ-018 In STOP, tx SHALL be 1; after SB_TICK ticks the block asserts tx_done_tick for one cycle.
REQ-019 On STOP completion with fifo_empty=0, the block SHALL pop (fifo_rd=1) in the same cycle as tx_done_tick and go directly to START, with no extra idle cycle.
REQ-020 On STOP completion with fifo_empty=1, the block SHALL go to IDLE.
REQ-021 Frame length SHALL be (1+DBIT)*16*DVSR + SB_TICK*DVSR cycles; changes on fifo_empty/fifo_data outside the pop cycle SHALL NOT affect the frame in progress.
REQ-022 fifo_rd SHALL never be asserted while fifo_empty=1, and SHALL never be asserted for two consecutive cycles.
REQ-023 tx SHALL be driven from a register (glitch-free).

Reset
REQ-024 With reset=0 at a rising edge: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, all counters and the shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame: tx=1 from the next edge, no pop and no tx_done_tick are generated, and the aborted word is lost.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state type/encoding and the default DBIT/SB_TICK/DVSR constants, shared with the receiver.
REQ-027 The baud divider SHALL be the sub-module baud_gen (mod-DVSR counter with synchronous clear, tick output).

Verification
REQ-028 Reset with DVSR=2: tx=1, fifo_rd=0, tx_busy=0 on the first edge after reset=0.
REQ-029 Send 0xA5 with DVSR=2, DBIT=8, SB_TICK=16: one fifo_rd pulse; tx = 0 (32 cycles), then 1,0,1,0,0,1,0,1 (32 cycles each), then 1 (32 cycles); tx_done_tick is asserted at cycle 320.
REQ-030 Three-word FIFO (0x00, 0xFF, 0x55): exactly 3 pops, frames back-to-back with zero idle gap, then IDLE with tx_busy=0.
REQ-031 SB_TICK=32, DVSR=2: the stop bit lasts 64 cycles and the frame lasts 352 cycles.
REQ-032 reset=0 asserted mid-DATA of 0x3C: tx=1 on the next edge; no tx_done_tick; a later word 0x81 is transmitted correctly after reset is released.
REQ-033 fifo_empty held 1 for 1000 cycles: fifo_rd is never asserted and tx stays 1.
